// File: rtl/sn7402_tester_if.sv
// sn7402_tester_if: control and pin-level bundle between the sequencer, its host and the NOR part
interface sn7402_tester_if;
  logic start, vcc, gnd, busy, done, pass;
  logic [3:0] a, b, y, fail_mask;
  modport master (input start, y, output vcc, gnd, a, b, busy, done, pass, fail_mask);
  modport slave (output start, y, input vcc, gnd, a, b, busy, done, pass, fail_mask);
endinterface

// File: rtl/sn7402_tester.sv
// sn7402_tester: powers an SN7402, sweeps rotated input patterns over all gates, flags per-gate mismatches
module sn7402_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES = 1
) (
  input logic clk,
  input logic reset_n,
  sn7402_tester_if.master bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(PASSES + 1);
  typedef enum logic [2:0] {IDLE, PWRUP, DRIVE, CHECK, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [PW-1:0] sweep;
  logic [1:0] vec, vec_n;
  logic [3:0] a_n, b_n, fail_n;
  logic settled, last, go;
  assign settled = cnt == CW'(SETTLE_CYCLES - 1);
  assign last = vec == 2'd3 && sweep == PW'(PASSES - 1);
  assign go = state == IDLE && bus.start;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      sweep <= '0;
      vec <= '0;
      bus.vcc <= 1'b0;
      bus.gnd <= 1'b1;
      bus.a <= '0;
      bus.b <= '0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.fail_mask <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == PWRUP || state == DRIVE) && !settled ? cnt + 1'b1 : '0;
      sweep <= state == IDLE ? '0 : state == CHECK && vec == 2'd3 ? sweep + 1'b1 : sweep;
      vec <= vec_n;
      bus.vcc <= go ? 1'b1 : state == DONE ? 1'b0 : bus.vcc;
      bus.gnd <= go ? 1'b0 : state == DONE ? 1'b1 : bus.gnd;
      bus.a <= a_n;
      bus.b <= b_n;
      bus.done <= state == DONE;
      bus.pass <= go ? 1'b0 : state == DONE ? bus.fail_mask == 4'd0 : bus.pass;
      bus.fail_mask <= go ? '0 : state == CHECK ? fail_n : bus.fail_mask;
    end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.start ? PWRUP : IDLE;
      PWRUP:   state_n = settled ? DRIVE : PWRUP;
      DRIVE:   state_n = settled ? CHECK : DRIVE;
      CHECK:   state_n = last ? DONE : DRIVE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // patterns follow the next vector so a/b only move on entry to DRIVE
  always_comb begin
    bus.busy = state != IDLE;
    vec_n = state == CHECK ? vec + 2'd1 : state == DRIVE ? vec : 2'd0;
    a_n = '0;
    b_n = '0;
    fail_n = bus.fail_mask;
    for (int g = 0; g < 4; g++) begin
      {a_n[g], b_n[g]} = state_n == DRIVE || state_n == CHECK ? vec_n + 2'(g) : 2'b00;
      fail_n[g] = bus.fail_mask[g] | (bus.y[g] !== ~(bus.a[g] | bus.b[g]));
    end
  end
endmodule

// File: tb/tb_sn7402_tester.sv
// tb_sn7402_tester: scoreboard bench driving a faultable SN7402 model under the sequencer
module tb_sn7402_tester;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0, fails = 0, cyc = 0, mode = 0, fgate = 0;
  typedef struct {logic [3:0] mask; logic pass; int cyc;} exp_t;
  exp_t q[$];
  logic [3:0] yv;
  sn7402_tester_if bus();
  sn7402_tester_if bus6();
  sn7402_tester dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  sn7402_tester #(.SETTLE_CYCLES(1), .PASSES(3)) dut6 (.clk(clk), .reset_n(reset_n), .bus(bus6));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // part under test: mode 1 stuck-0, 2 stuck-1, 3 B pin shorted to A, 4 output floating X
  function automatic logic dev(input logic ai, input logic bi, input bit hit);
    return !hit ? ~(ai | bi) : mode == 1 ? 1'b0 : mode == 2 ? 1'b1 :
           mode == 3 ? ~ai : mode == 4 ? 1'bx : ~(ai | bi);
  endfunction
  always_comb begin
    yv = '0;
    for (int g = 0; g < 4; g++)
      yv[g] = bus.vcc && !bus.gnd ? dev(bus.a[g], bus.b[g], g == fgate) : 1'b0;
  end
  assign bus.y = yv;
  assign bus6.y = ~(bus6.a | bus6.b);
  // reference: a NOR output is high only for pattern 0; gate g sees patterns (v+g)%4
  function automatic logic [3:0] ref_mask(input int m, input int fg);
    logic [3:0] r;
    r = '0;
    for (int v = 0; v < 4; v++)
      for (int g = 0; g < 4; g++) begin
        int p;
        bit want, ai;
        p = (v + g) % 4;
        want = p == 0;
        ai = p >= 2;
        if (g == fg && m != 0)
          r[g] = r[g] | (m == 4 ? 1'b1 : m == 1 ? want : m == 2 ? !want : ((!ai) != want));
      end
    return r;
  endfunction
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_unexpected: got done=1 expected no pending run");
      end else begin
        e = q.pop_front();
        chk("fail_mask", bus.fail_mask, e.mask);
        chk("pass", bus.pass, e.pass);
        chk("done_cycle", cyc, e.cyc);
        chk("vcc_off", bus.vcc, 0);
        chk("gnd_on", bus.gnd, 1);
      end
    end
  end
  task automatic run(input int m, input int fg, input bit probe);
    exp_t e;
    mode = m;
    fgate = fg;
    @(negedge clk);
    e.mask = ref_mask(m, fg);
    e.pass = e.mask == 4'd0;
    e.cyc = cyc + 16;
    q.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (probe) begin
      chk("vcc_on", bus.vcc, 1);
      chk("gnd_off", bus.gnd, 0);
      chk("busy", bus.busy, 1);
    end
    for (int n = 1; n <= 40 && q.size() != 0; n++) begin
      @(negedge clk);
      if (probe && n >= 2 && n <= 13)
        chk($sformatf("gate0_ab_n%0d", n), {bus.a[0], bus.b[0]}, (n - 2) / 3);
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask
  initial begin
    int dn, at;
    dn = 0;
    at = 0;
    bus.start = 1'b0;
    bus6.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vcc", bus.vcc, 0);
    chk("rst_gnd", bus.gnd, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_fail_mask", bus.fail_mask, 0);
    chk("rst_ab", {bus.a, bus.b}, 0);
    reset_n = 1'b1;
    run(0, 0, 1);
    repeat (3) @(negedge clk);
    chk("pass_held", bus.pass, 1);
    chk("vcc_idle", bus.vcc, 0);
    run(1, 2, 0);
    run(3, 2, 0);
    run(4, 1, 0);
    repeat (10) run($urandom_range(0, 4), $urandom_range(0, 3), 0);
    // reset while vector 2 is applied
    mode = 1;
    fgate = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_fail_mask", bus.fail_mask, 4'b0001);
    chk("mid_busy", bus.busy, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_vcc", bus.vcc, 0);
    chk("mid_rst_gnd", bus.gnd, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_fail_mask", bus.fail_mask, 0);
    chk("mid_rst_ab", {bus.a, bus.b}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run(0, 0, 0);
    // three sweeps, one settle cycle, second start while busy
    @(negedge clk);
    bus6.start = 1'b1;
    @(negedge clk);
    bus6.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 4) bus6.start = 1'b1;
      if (n == 5) bus6.start = 1'b0;
      if (bus6.done) begin
        dn++;
        at = n;
      end
    end
    chk("p3_done_count", dn, 1);
    chk("p3_done_cycle", at, 26);
    chk("p3_pass", bus6.pass, 1);
    chk("p3_fail_mask", bus6.fail_mask, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
